// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the iterative execute unit.
// Holds the fixed 4-bit ALUControl code map, the execute FSM state encoding,
// the shift-type encoding and the default datapath width.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB_CMP = 4'b0011;  // SUB used for branch compare
    localparam logic [3:0] ALU_SLL     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLTU    = 4'b1000;
    localparam logic [3:0] ALU_SRA     = 4'b1001;
    localparam logic [3:0] ALU_XOR     = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_t;

    // True for the three codes handled by the iterative shifter.
    function automatic logic is_shift_code(input logic [3:0] code);
        logic r;
        case (code)
            ALU_SLL, ALU_SRL, ALU_SRA: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Maps a shift code to its shift type; non-shift codes map to SLL (unused).
    function automatic shift_t shift_type_of(input logic [3:0] code);
        shift_t r;
        case (code)
            ALU_SRL: r = SH_SRL;
            ALU_SRA: r = SH_SRA;
            default: r = SH_SLL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU datapath: AND/OR/ADD/SUB/SLT/SLTU/XOR.
// Shift codes and undefined codes fall through to ADD; shifts are handled by
// the iterative unit around this core.
// Ports:
//   i_ctrl  - 4-bit ALUControl code
//   i_a     - operand A
//   i_b     - operand B
//   o_y     - combinational result
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      i_ctrl,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y
);

    logic w_lt_s;
    logic w_lt_u;

    // Comparison flags for SLT / SLTU.
    always_comb begin
        w_lt_s = ($signed(i_a) < $signed(i_b));
        w_lt_u = (i_a < i_b);
    end

    // Operation select; ADD/SUB wrap modulo 2^XLEN.
    always_comb begin
        o_y = i_a + i_b;
        case (i_ctrl)
            ALU_AND:              o_y = i_a & i_b;
            ALU_OR:               o_y = i_a | i_b;
            ALU_SUB_CMP, ALU_SUB: o_y = i_a - i_b;
            ALU_SLT:              o_y = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU:             o_y = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_XOR:              o_y = i_a ^ i_b;
            default:              o_y = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/alu_iter_exec.sv
// Multi-cycle EX-stage execute unit. Non-shift operations finish one cycle
// after acceptance; shifts move the accumulator one bit per cycle, giving a
// latency of shamt+1. Valid/ready handshake on both operand input and result.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - operand handshake (in_ready high only in IDLE)
//   alu_ctrl, op_a, op_b  - operation code and operands (op_b low bits = shamt)
//   out_valid / out_ready - result handshake (out_valid high only in DONE)
//   result, zero          - registered result and result==0 flag
//   busy                  - high while shifting
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    state_t               r_state;
    state_t               w_next_state;
    logic [XLEN-1:0]      r_acc;
    logic [SHAMT_W-1:0]   r_cnt;
    shift_t               r_shtype;
    logic [XLEN-1:0]      r_result;
    logic                 r_zero;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [XLEN-1:0]      w_core_y;
    logic [XLEN-1:0]      w_acc_shifted;
    logic [XLEN-1:0]      w_next_result;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_accept;
    logic                 w_start_shift;

    alu_core #(.XLEN(XLEN)) u_core (
        .i_ctrl (alu_ctrl),
        .i_a    (op_a),
        .i_b    (op_b),
        .o_y    (w_core_y)
    );

    // Acceptance and shift-start decode. r_in_ready is only set while IDLE.
    always_comb begin
        w_shamt       = op_b[SHAMT_W-1:0];
        w_accept      = in_valid & r_in_ready;
        w_start_shift = w_accept & is_shift_code(alu_ctrl) & (w_shamt != {SHAMT_W{1'b0}});
    end

    // One-bit step of the accumulator in the latched direction.
    always_comb begin
        w_acc_shifted = r_acc;
        case (r_shtype)
            SH_SLL:  w_acc_shifted = {r_acc[XLEN-2:0], 1'b0};
            SH_SRL:  w_acc_shifted = {1'b0, r_acc[XLEN-1:1]};
            SH_SRA:  w_acc_shifted = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_shifted = r_acc;
        endcase
    end

    // Next-state and next-result logic.
    always_comb begin
        w_next_state  = r_state;
        w_next_result = r_result;
        case (r_state)
            ST_IDLE: begin
                if (w_start_shift) begin
                    w_next_state = ST_SHIFT;
                end else if (w_accept) begin
                    w_next_state = ST_DONE;
                    // A zero-amount shift passes op_a straight through.
                    w_next_result = is_shift_code(alu_ctrl) ? op_a : w_core_y;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                    w_next_state  = ST_DONE;
                    w_next_result = w_acc_shifted;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, result and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_result    <= {XLEN{1'b0}};
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_result    <= w_next_result;
            r_zero      <= (w_next_result == {XLEN{1'b0}});
            r_in_ready  <= (w_next_state == ST_IDLE);
            r_out_valid <= (w_next_state == ST_DONE);
            r_busy      <= (w_next_state == ST_SHIFT);
        end
    end

    // Shift accumulator, remaining-count and latched shift type.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= {XLEN{1'b0}};
            r_cnt    <= {SHAMT_W{1'b0}};
            r_shtype <= SH_SLL;
        end else if (w_start_shift) begin
            r_acc    <= op_a;
            r_cnt    <= w_shamt;
            r_shtype <= shift_type_of(alu_ctrl);
        end else if (r_state == ST_SHIFT) begin
            r_acc    <= w_acc_shifted;
            r_cnt    <= r_cnt - {{(SHAMT_W-1){1'b0}}, 1'b1};
            r_shtype <= r_shtype;
        end else begin
            r_acc    <= r_acc;
            r_cnt    <= r_cnt;
            r_shtype <= r_shtype;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign busy      = r_busy;

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
Multi-cycle execute unit that consumes the 4-bit ALUControl code produced by the ALU control decoder, together with two operands, and returns a registered result plus a zero flag. It sits in the EX stage between operand selection and writeback/branch resolution. Single-cycle operations complete in one clock. Shifts iterate one bit per cycle to keep area down. Operand input and result output each use a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width in bits.
SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operands and code are valid this cycle.
in_ready  output  1  unit can accept a new operation.
alu_ctrl  input  4  operation code (see Behaviour).
op_a  input  XLEN  operand A (rs1).
op_b  input  XLEN  operand B (rs2 or immediate); op_b[SHAMT_W-1:0] is the shift amount.
out_valid  output  1  result and zero flag are valid.
out_ready  input  1  consumer accepts the result.
result  output  XLEN  registered result.
zero  output  1  result == 0; registered together with result.
busy  output  1  high in SHIFT state.

Behaviour:
- Code map (fixed):
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (branch compare); 0100 SLL; 0101 SRL.
  - 0110 SUB; 0111 SLT (signed); 1000 SLTU; 1001 SRA; 1010 XOR.
  - Any other code executes as ADD.
- Arithmetic:
  - ADD and SUB wrap modulo 2^XLEN; no overflow or carry output.
  - SLT and SLTU return 1 or 0 zero-extended to XLEN.
  - SRA replicates op_a[XLEN-1].
- Reset (rst_n low, asynchronous):
  - state=IDLE; result=0; zero=0; out_valid=0; busy=0.
  - in_ready goes to 1 once reset is released.
  - Reset mid-operation aborts the operation with no result delivered.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1; accept on in_valid & in_ready.
  - Non-shift code: compute combinationally, register result and zero, go to DONE. Latency is 1 cycle (out_valid high on the edge after acceptance).
  - Shift code with shamt==0: result=op_a, go to DONE (latency 1).
  - Shift code with shamt>0: load acc=op_a, cnt=shamt, latch the shift type, go to SHIFT.
- SHIFT:
  - busy=1, in_ready=0.
  - Each cycle shift acc by 1 in the latched direction/type, then cnt=cnt-1.
  - When cnt==1 at the edge, perform the final shift, register result and zero, go to DONE.
  - Total latency is shamt+1 cycles from acceptance to out_valid.
- DONE:
  - out_valid=1, in_ready=0.
  - result and zero are held stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
  - No same-cycle accept/retire bypass: peak throughput is one op every 2 cycles.
- Input handling:
  - Input fields are sampled only at acceptance; changes to op_a, op_b or alu_ctrl after acceptance have no effect.
  - in_valid is ignored while in_ready=0; the upstream stage must hold its request.
- Other boundaries:
  - out_ready asserted while out_valid=0 is ignored.
  - shamt uses only the low SHAMT_W bits of op_b.
  - Maximum shamt (31) gives 32-cycle latency.

Decomposition:
- Shared package alu_pkg:
  - localparams for all 11 ALU codes (ALU_AND … ALU_XOR), reused by the ALU control decoder.
  - State encoding for IDLE/SHIFT/DONE.
  - XLEN default.
- One natural sub-module, alu_core: purely combinational AND/OR/ADD/SUB/SLT/SLTU/XOR datapath, instanced once.
- The FSM, shift accumulator and counter live in alu_iter_exec.

Test Plan:
- ADD a=5, b=7 accepted at cycle 0 -> out_valid at cycle 1; result=12, zero=0; retire with out_ready=1, in_ready back to 1 at cycle 2.
- Compare and SUB:
  - SUB (0011) a=b=0x1234 -> result=0, zero=1.
  - SUB (0110) a=0, b=1 -> result=0xFFFFFFFF.
- Set-less-than: SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0; undefined code 1111 with a=2, b=3 -> 5.
- SRA a=0x80000000, shamt=4 -> busy for 4 cycles, in_ready=0 throughout, out_valid at cycle 5, result=0xF8000000. SLL a=1, shamt=0 -> result=1 at cycle 1.
- Backpressure: XOR a=0xFF, b=0x0F with out_ready=0 for 3 cycles -> result=0xF0 held stable with out_valid=1, and a second in_valid is not accepted until after retire.
- Reset mid-shift: SRL shamt=20, rst_n low at cycle 6 -> outputs 0 immediately, state IDLE; after release, ADD 1+1 -> 2 with latency 1.
